// File: rtl/spi_flash_read_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash read arbiter.
package spi_flash_read_arbiter_pkg;

  localparam logic [7:0]  SPI_CMD_READ = 8'h03;
  localparam int unsigned FRAME_BITS   = 64;
  localparam int unsigned ADDR_W       = 24;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BIT_CNT_W    = 7;
  localparam int unsigned DIV_CNT_W    = 4;
  localparam int unsigned GAP_CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_e;

  // Full SPI read frame: command, address, then 32 dummy bits clocked during data phase
  function automatic logic [FRAME_BITS-1:0] read_frame(input logic [ADDR_W-1:0] addr);
    return {SPI_CMD_READ, addr, 32'h0};
  endfunction

  // Flash returns the lowest-addressed byte first; place it in the low byte
  function automatic logic [DATA_W-1:0] bswap32(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 frame engine: divides the system clock into flash_clk, shifts a
// 64-bit frame out MSB first and samples the 32 data bits on MISO.
//   start   : load frame and present its first bit (one cycle, from SETUP)
//   frame   : 64-bit command/address/dummy frame
//   miso    : flash data in, sampled on each flash_clk rising edge
//   sck     : flash clock, idle low
//   mosi    : flash data out, changes on falling edges
//   oeb     : io0 output enable (active low), high during the data phase
//   word_c  : assembled read word, little-endian byte order
//   done_c  : high in the cycle of the final falling edge
module spi_flash_shifter
  import spi_flash_read_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  sck,
  output logic                  mosi,
  output logic                  oeb,
  output logic [DATA_W-1:0]     word_c,
  output logic                  done_c
);

  logic                  active;
  logic [DIV_CNT_W-1:0]  div_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [DATA_W-1:0]     rx;
  logic                  div_end_c;

  assign div_end_c = (div_cnt == DIV_CNT_W'(CLK_DIV - 1));
  assign done_c    = active && div_end_c && sck && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  assign word_c    = bswap32(rx);

  // Half-period divider, clock toggling, shift-out and sample-in
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx      <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      oeb     <= 1'b0;
    end else if (start) begin
      // shreg holds the bits still to be sent after the one on mosi
      shreg   <= {frame[FRAME_BITS-2:0], 1'b0};
      mosi    <= frame[FRAME_BITS-1];
      oeb     <= 1'b0;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      rx      <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (div_end_c) begin
        div_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
          if (bit_cnt >= BIT_CNT_W'(FRAME_BITS / 2)) begin
            rx <= {rx[DATA_W-2:0], miso};
          end
        end else begin
          sck <= 1'b0;
          if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
            active <= 1'b0;
            mosi   <= 1'b0;
            oeb    <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            mosi    <= shreg[FRAME_BITS-1];
            // Next bit index >= 32 means the data phase: release io0
            oeb     <= (bit_cnt >= BIT_CNT_W'(FRAME_BITS / 2 - 1));
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_flash_read_arbiter.sv
// Round-robin arbiter sharing a single-IO SPI flash between two read ports.
// Each grant runs one 0x03 read of a 32-bit word at the word-aligned address.
//   req0_* / req1_* : valid/addr in, one-cycle ready pulse with rdata out
//   busy, grant     : transaction in progress and the port being served
//   flash_*         : chip select, clock, io0 out/enable, io1 in
module spi_flash_read_arbiter
  import spi_flash_read_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned CSB_GAP = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              busy,
  output logic              grant,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_io0_do,
  output logic              flash_io0_oeb,
  input  logic              flash_io1_di
);

  state_e               state;
  logic                 last_grant;
  logic [ADDR_W-1:0]    addr_q;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 win_c;
  logic [ADDR_W-1:0]    addr_sel_c;
  logic                 start_c;
  logic                 done_c;
  logic [DATA_W-1:0]    word_c;

  // Winner: the lone requester, or under contention the port not served last
  always_comb begin
    win_c = req1_valid;
    if (req0_valid && req1_valid) begin
      win_c = ~last_grant;
    end
    addr_sel_c = win_c ? req1_addr : req0_addr;
  end

  assign start_c = (state == ST_SETUP);

  spi_flash_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clock  (clock),
    .resetb (resetb),
    .start  (start_c),
    .frame  (read_frame(addr_q)),
    .miso   (flash_io1_di),
    .sck    (flash_clk),
    .mosi   (flash_io0_do),
    .oeb    (flash_io0_oeb),
    .word_c (word_c),
    .done_c (done_c)
  );

  // Transaction sequencing, chip select and response registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      busy       <= 1'b0;
      addr_q     <= '0;
      gap_cnt    <= '0;
      flash_csb  <= 1'b1;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            grant      <= win_c;
            last_grant <= win_c;
            addr_q     <= addr_sel_c & ~ADDR_W'(3);
            busy       <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          flash_csb <= 1'b0;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (done_c) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          flash_csb <= 1'b1;
          gap_cnt   <= '0;
          if (grant) begin
            req1_rdata <= word_c;
            req1_ready <= 1'b1;
          end else begin
            req0_rdata <= word_c;
            req0_ready <= 1'b1;
          end
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_CNT_W'(CSB_GAP - 1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// Scoreboard bench for spi_flash_read_arbiter with a behavioural SPI flash model.
// A CLK_DIV=1 instance carries the main traffic; a CLK_DIV=3 instance checks timing scaling.
module tb_spi_flash_read_arbiter;

  localparam int CSB_GAP = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetb;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_addr, req1_addr;
  logic [31:0] req0_rdata, req1_rdata;
  logic        busy, grant, flash_csb, flash_clk, flash_io0_do, flash_io0_oeb;
  logic        flash_io1_di = 1'b0;

  logic        req0_valid3, req1_valid3, req0_ready3, req1_ready3;
  logic [23:0] req0_addr3, req1_addr3;
  logic [31:0] req0_rdata3, req1_rdata3;
  logic        busy3, grant3, flash_csb3, flash_clk3, flash_io0_do3, flash_io0_oeb3;
  logic        flash_io1_di3 = 1'b0;

  spi_flash_read_arbiter #(.CLK_DIV(1), .CSB_GAP(CSB_GAP)) dut (
    .clock(clock), .resetb(resetb),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .busy(busy), .grant(grant), .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0_do(flash_io0_do), .flash_io0_oeb(flash_io0_oeb), .flash_io1_di(flash_io1_di)
  );

  spi_flash_read_arbiter #(.CLK_DIV(3), .CSB_GAP(CSB_GAP)) dut3 (
    .clock(clock), .resetb(resetb),
    .req0_valid(req0_valid3), .req0_addr(req0_addr3), .req0_ready(req0_ready3), .req0_rdata(req0_rdata3),
    .req1_valid(req1_valid3), .req1_addr(req1_addr3), .req1_ready(req1_ready3), .req1_rdata(req1_rdata3),
    .busy(busy3), .grant(grant3), .flash_csb(flash_csb3), .flash_clk(flash_clk3),
    .flash_io0_do(flash_io0_do3), .flash_io0_oeb(flash_io0_oeb3), .flash_io1_di(flash_io1_di3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Flash contents: one known word, otherwise an address-derived pattern
  function automatic logic [31:0] word_at(input logic [23:0] a);
    if (a == 24'h000104) return 32'hDEADBEEF;
    return {a[7:0], ~a[7:0], a[15:8], 8'h5A};
  endfunction

  // Serial order of the data phase: byte at addr first, each byte MSB first
  function automatic logic [31:0] mk_stream(input logic [23:0] a);
    logic [31:0] w;
    w = word_at(a);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // ---------------- flash model for dut ----------------
  int          rc = 0;
  int          oeb_bad = 0;
  logic [31:0] cap = '0;
  logic [31:0] stream = '0;

  always @(negedge flash_csb) begin
    rc = 0; cap = '0; oeb_bad = 0;
  end
  always @(posedge flash_clk) if (!flash_csb) begin
    if (flash_io0_oeb !== (rc >= 32)) oeb_bad++;
    if (rc < 32) cap = {cap[30:0], flash_io0_do};
    rc++;
    if (rc == 32) stream = mk_stream(cap[23:0]);
  end
  always @(negedge flash_clk) if (!flash_csb && rc >= 32 && rc < 64) flash_io1_di = stream[63-rc];

  // ---------------- flash model for dut3 ----------------
  int          rc3 = 0;
  logic [31:0] cap3 = '0;
  logic [31:0] stream3 = '0;

  always @(negedge flash_csb3) begin
    rc3 = 0; cap3 = '0;
  end
  always @(posedge flash_clk3) if (!flash_csb3) begin
    if (rc3 < 32) cap3 = {cap3[30:0], flash_io0_do3};
    rc3++;
    if (rc3 == 32) stream3 = mk_stream(cap3[23:0]);
  end
  always @(negedge flash_clk3) if (!flash_csb3 && rc3 >= 32 && rc3 < 64) flash_io1_di3 = stream3[63-rc3];

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic        port;
    logic [31:0] cmdaddr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] mdl_rdata [2];
  int          cyc = 0;
  int          t_grant = 0;
  int          csb_hi = 0;
  logic        busy_q = 1'b0;
  logic        csb_q = 1'b1;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (busy && !busy_q) t_grant = cyc;
    busy_q = busy;
    if (!flash_csb && csb_q) check("csb_gap_min", 64'(csb_hi >= CSB_GAP), 1);
    if (flash_csb) csb_hi++; else csb_hi = 0;
    csb_q = flash_csb;
    if (req0_ready || req1_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", {62'h0, req1_ready, req0_ready}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ready_port", {62'h0, req1_ready, req0_ready}, e.port ? 64'd2 : 64'd1);
        check("rdata", e.port ? req1_rdata : req0_rdata, e.data);
        check("other_rdata", e.port ? req0_rdata : req1_rdata, mdl_rdata[!e.port]);
        mdl_rdata[e.port] = e.data;
        check("mosi_cmd_addr", cap, e.cmdaddr);
        check("latency", 64'(cyc - t_grant), 130);
        check("grant", grant, e.port);
        check("oeb_phase", 64'(oeb_bad), 0);
      end
    end
  end

  task automatic push(input logic port, input logic [23:0] addr);
    exp_t x;
    x.port    = port;
    x.cmdaddr = {8'h03, addr[23:2], 2'b00};
    x.data    = word_at({addr[23:2], 2'b00});
    exp_q.push_back(x);
  endtask

  // Wait for the scoreboard to drain, then withdraw both requests
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    exp_q.delete();
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t3;
    int hi;
    int hi_first;
    logic seen0;

    req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
    req0_valid3 = 0; req1_valid3 = 0; req0_addr3 = '0; req1_addr3 = '0;
    mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    resetb = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_csb", flash_csb, 1);
    check("rst_clk", flash_clk, 0);
    check("rst_outs", {58'h0, flash_io0_do, flash_io0_oeb, busy, grant, req0_ready, req1_ready}, 0);
    check("rst_rdata", {req0_rdata, req1_rdata}, 0);
    check("rst_csb3", flash_csb3, 1);
    @(negedge clock);
    resetb = 1'b1;

    // Single port-0 read of the known word
    push(1'b0, 24'h000104);
    req0_addr = 24'h000104; req0_valid = 1'b1;
    drain(400);
    repeat (20) @(negedge clock);
    check("idle_busy", busy, 0);

    // Contention from reset: strict alternation starting with port 0
    do_reset();
    push(1'b0, 24'h000000); push(1'b1, 24'h000010);
    push(1'b0, 24'h000000); push(1'b1, 24'h000010);
    req0_addr = 24'h000000; req1_addr = 24'h000010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    drain(1000);
    repeat (10) @(negedge clock);

    // Unaligned address is sent word-aligned
    push(1'b0, 24'h000107);
    req0_addr = 24'h000107; req0_valid = 1'b1;
    drain(400);
    repeat (10) @(negedge clock);

    // Reset in the middle of the shift phase aborts without a ready pulse
    push(1'b0, 24'h000020);
    req0_addr = 24'h000020; req0_valid = 1'b1;
    n = 0;
    while (rc < 20 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("reach_bit20", 64'(rc >= 20), 1);
    #2;
    resetb = 1'b0;
    #1;
    check("abort_csb", flash_csb, 1);
    check("abort_clk", flash_clk, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    req0_valid = 1'b0;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    repeat (5) @(negedge clock);
    push(1'b1, 24'h000040);
    req1_addr = 24'h000040; req1_valid = 1'b1;
    drain(400);
    repeat (10) @(negedge clock);

    // Port 1 withdraws mid-transaction; read still completes exactly once
    push(1'b1, 24'h000080);
    req1_addr = 24'h000080; req1_valid = 1'b1;
    repeat (40) @(negedge clock);
    req1_valid = 1'b0;
    drain(400);
    repeat (20) @(negedge clock);
    check("drop_busy", busy, 0);
    check("drop_csb", flash_csb, 1);

    // CLK_DIV=3 instance: clock half-periods and latency scale
    req1_addr3 = 24'h000200; req1_valid3 = 1'b1;
    t3 = -1; hi = 0; hi_first = -1; seen0 = 1'b0; n = 0;
    while (!req1_ready3 && n < 800) begin
      @(negedge clock);
      n++;
      if (busy3 && t3 < 0) t3 = cyc;
      if (req0_ready3) seen0 = 1'b1;
      if (flash_clk3) hi++;
      else begin
        if (hi > 0 && hi_first < 0) hi_first = hi;
        hi = 0;
      end
    end
    req1_valid3 = 1'b0;
    check("div3_ready_seen", req1_ready3, 1);
    check("div3_latency", 64'(cyc - t3), 386);
    check("div3_clk_high", 64'(hi_first), 3);
    check("div3_rdata", req1_rdata3, word_at(24'h000200));
    check("div3_cmd_addr", cap3, 32'h03000200);
    check("div3_port0_quiet", {63'h0, seen0}, 0);
    repeat (10) @(negedge clock);

    check("queue_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
